// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with iterative multiply/divide behind a Start/Done handshake.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       Control,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivZero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam logic [SHW:0] NW = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] ONE = (SHW+1)'(1);
  state_t state;
  logic [SHW:0] cnt;
  logic [2*WIDTH-1:0] p, mul_step, div_step, prod;
  logic [WIDTH-1:0] m, a1, res, add, sub, m1, m2, q_fix, r_fix, fix_lo, fix_hi;
  logic [WIDTH:0] sum, rs, diff;
  logic [SHW-1:0] sh;
  logic ovf, n1, n2, neg, s1, dz, isdiv, multi;
  assign add = Src1 + Src2;
  assign sub = Src1 - Src2;
  assign sh = Src2[SHW-1:0];
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (Control)
      4'h1: begin
        res = add;
        ovf = (Src1[WIDTH-1] == Src2[WIDTH-1]) && (add[WIDTH-1] != Src1[WIDTH-1]);
      end
      4'h2: begin
        res = sub;
        ovf = (Src1[WIDTH-1] != Src2[WIDTH-1]) && (sub[WIDTH-1] != Src1[WIDTH-1]);
      end
      4'h3: res = Src1 & Src2;
      4'h4: res = Src1 | Src2;
      4'h5: res = WIDTH'($signed(Src1) < $signed(Src2));
      4'h6: res = Src1 ^ Src2;
      4'h7: res = ~(Src1 | Src2);
      4'h8: res = WIDTH'(Src1 < Src2);
      4'h9: res = Src1 << sh;
      4'hA: res = Src1 >> sh;
      4'hB: res = $signed(Src1) >>> sh;
      default: res = '0;
    endcase
  end
  // Signed mult/div run over magnitudes; Control[0] set means unsigned.
  assign multi = &Control[3:2];
  assign n1 = ~Control[0] & Src1[WIDTH-1];
  assign n2 = ~Control[0] & Src2[WIDTH-1];
  assign m1 = n1 ? -Src1 : Src1;
  assign m2 = n2 ? -Src2 : Src2;
  // p = {acc, multiplier} for multiply, {remainder, dividend/quotient} for divide.
  assign sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign mul_step = {sum, p[WIDTH-1:1]};
  assign rs = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign diff = rs - {1'b0, m};
  assign div_step = {diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0], p[WIDTH-2:0], ~diff[WIDTH]};
  assign prod = neg ? -p : p;
  assign q_fix = neg ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign r_fix = s1 ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  assign fix_lo = isdiv ? (dz ? '1 : q_fix) : prod[WIDTH-1:0];
  assign fix_hi = isdiv ? (dz ? a1 : r_fix) : prod[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      Busy <= 1'b0;
      Done <= 1'b0;
      Lo <= '0;
      Hi <= '0;
      Zero <= 1'b0;
      Overflow <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          Busy <= 1'b1;
          if (!multi) begin
            Lo <= res;
            Hi <= '0;
            Zero <= res == '0;
            Overflow <= ovf;
            DivZero <= 1'b0;
            Done <= 1'b1;
            state <= DONE;
          end else begin
            isdiv <= Control[1];
            m <= Control[1] ? m2 : m1;
            p <= {{WIDTH{1'b0}}, Control[1] ? m1 : m2};
            neg <= n1 ^ n2;
            s1 <= n1;
            dz <= Control[1] && Src2 == '0;
            a1 <= Src1;
            cnt <= NW;
            state <= RUN;
          end
        end
        RUN: begin
          p <= isdiv ? div_step : mul_step;
          cnt <= cnt - ONE;
          state <= cnt == ONE ? FIX : RUN;
        end
        FIX: begin
          Lo <= fix_lo;
          Hi <= fix_hi;
          Zero <= fix_lo == '0;
          Overflow <= 1'b0;
          DivZero <= dz;
          Done <= 1'b1;
          state <= DONE;
        end
        default: begin
          Done <= 1'b0;
          Busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scoreboard bench for alu_mc at WIDTH = 32.
module tb_alu_mc;
  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic z;
    logic o;
    logic d;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] control = '0;
  logic [31:0] src1 = '0, src2 = '0;
  logic busy, done, zero, overflow, divzero;
  logic [31:0] lo, hi;
  int checks = 0;
  int failures = 0;
  logic [31:0] last_lo = '0, last_hi = '0;
  res_t sb[$];
  always #5 clk = ~clk;
  alu_mc #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .Control(control), .Src1(src1), .Src2(src2),
    .Busy(busy), .Done(done), .Lo(lo), .Hi(hi), .Zero(zero), .Overflow(overflow), .DivZero(divzero)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Reference model built from wide signed/unsigned arithmetic.
  function automatic res_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb_, s, q;
    logic [63:0] pr;
    r = '0;
    sa = $signed(a);
    sb_ = $signed(b);
    case (c)
      4'h1: begin s = sa + sb_; r.lo = s[31:0]; r.o = longint'($signed(s[31:0])) != s; end
      4'h2: begin s = sa - sb_; r.lo = s[31:0]; r.o = longint'($signed(s[31:0])) != s; end
      4'h3: r.lo = a & b;
      4'h4: r.lo = a | b;
      4'h5: r.lo = {31'b0, sa < sb_};
      4'h6: r.lo = a ^ b;
      4'h7: r.lo = ~(a | b);
      4'h8: r.lo = {31'b0, a < b};
      4'h9: r.lo = a << b[4:0];
      4'hA: r.lo = a >> b[4:0];
      4'hB: begin s = sa >>> b[4:0]; r.lo = s[31:0]; end
      4'hC: begin pr = sa * sb_; {r.hi, r.lo} = pr; end
      4'hD: begin pr = {32'b0, a} * {32'b0, b}; {r.hi, r.lo} = pr; end
      4'hE, 4'hF: begin
        if (b == 0) begin
          r.lo = '1;
          r.hi = a;
          r.d = 1'b1;
        end else if (c == 4'hE) begin
          q = sa / sb_;
          s = sa % sb_;
          r.lo = q[31:0];
          r.hi = s[31:0];
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: r.lo = '0;
    endcase
    r.z = r.lo == 0;
    return r;
  endfunction
  task automatic wait_done(input string tag, input int lat);
    int n;
    res_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && lat > 1) begin
        chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
        chk({tag, "_held"}, {lo, hi}, {last_lo, last_hi});
      end
    end while (!done && n < 200);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_busy_done"}, {63'b0, busy}, 64'd1);
    chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_res"}, {lo, hi}, {e.lo, e.hi});
      chk({tag, "_flags"}, {61'b0, zero, overflow, divzero}, {61'b0, e.z, e.o, e.d});
      last_lo = e.lo;
      last_hi = e.hi;
    end
    @(negedge clk);
    chk({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
  endtask
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    control = c;
    src1 = a;
    src2 = b;
    sb.push_back(model(c, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    control = 4'($urandom);
    src1 = $urandom;
    src2 = $urandom;
    wait_done(tag, c >= 4'hC ? 34 : 1);
  endtask
  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {62'b0, busy, done}, 64'd0);
    chk("rst_res", {lo, hi}, 64'd0);
    chk("rst_flags", {61'b0, zero, overflow, divzero}, 64'd0);
    rst_n = 1'b1;
    run_op("add_ovf", 4'h1, 32'h7FFFFFFF, 32'h1);
    chk("add_ovf_lo", {32'b0, lo}, 64'h80000000);
    run_op("sub_zero", 4'h2, 32'd5, 32'd5);
    chk("sub_zero_z", {63'b0, zero}, 64'd1);
    run_op("sub_ovf", 4'h2, 32'h80000000, 32'h1);
    run_op("slt", 4'h5, 32'hFFFFFFFF, 32'h1);
    chk("slt_lo", {32'b0, lo}, 64'd1);
    run_op("sltu", 4'h8, 32'hFFFFFFFF, 32'h1);
    chk("sltu_lo", {32'b0, lo}, 64'd0);
    run_op("sra", 4'hB, 32'h80000000, 32'h24);
    chk("sra_lo", {32'b0, lo}, 64'hF8000000);
    run_op("nop", 4'h0, 32'h1234, 32'h5678);
    run_op("and", 4'h3, 32'hF0F0F0F0, 32'hFF00FF00);
    run_op("or", 4'h4, 32'hF0F0F0F0, 32'h0F0F0001);
    run_op("xor", 4'h6, 32'hAAAA5555, 32'hFFFF0000);
    run_op("nor", 4'h7, 32'h0000FFFF, 32'h00FF0000);
    run_op("sll", 4'h9, 32'h00000081, 32'hFFFFFFE7);
    run_op("srl", 4'hA, 32'h80000000, 32'h1F);
    run_op("mult", 4'hC, 32'hFFFFFFFD, 32'd7);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("multu", 4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("mult_mn", 4'hC, 32'h80000000, 32'hFFFFFFFF);
    run_op("div", 4'hE, 32'hFFFFFFF9, 32'd2);
    chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_z", 4'hF, 32'd100, 32'd0);
    chk("divu_z_hilo", {hi, lo}, 64'h00000064_FFFFFFFF);
    run_op("div_z", 4'hE, 32'hFFFFFFFB, 32'd0);
    run_op("div_mn", 4'hE, 32'h80000000, 32'hFFFFFFFF);
    chk("div_mn_hilo", {hi, lo}, 64'h00000000_80000000);
    run_op("div_neg", 4'hE, 32'd7, 32'hFFFFFFFE);
    run_op("div_zq", 4'hE, 32'd3, 32'd5);
    run_op("divu", 4'hF, 32'hFFFFFFF0, 32'd7);
    // Start held high across a whole DIV: the DONE cycle must not re-accept.
    @(negedge clk);
    start = 1'b1;
    control = 4'hE;
    src1 = 32'hFFFFFF9C;
    src2 = 32'd7;
    sb.push_back(model(4'hE, 32'hFFFFFF9C, 32'd7));
    @(posedge clk);
    wait_done("held_div", 34);
    control = 4'h1;
    src1 = 32'd40;
    src2 = 32'd2;
    sb.push_back(model(4'h1, 32'd40, 32'd2));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("held_add", 1);
    // Reset in the middle of a MULT aborts it with no Done.
    @(negedge clk);
    start = 1'b1;
    control = 4'hC;
    src1 = 32'd123;
    src2 = 32'd456;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_pre", {62'b0, busy, done}, 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ctl", {62'b0, busy, done}, 64'd0);
    chk("abort_res", {lo, hi}, 64'd0);
    chk("abort_flags", {61'b0, zero, overflow, divzero}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk("abort_no_done", {63'b0, seen}, 64'd0);
    last_lo = '0;
    last_hi = '0;
    run_op("post_add", 4'h1, 32'd1000, 32'hFFFFFFFF);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
